// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Package   : keypad_pkg
// Purpose   : Shared constants and state encoding for the 4x4 keypad scanner.
// Revision  : 1.0  initial release
// ============================================================================
package keypad_pkg;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int CODE_W = 4;

  // Row drive after reset: row 0 driven low, all others released high.
  localparam logic [ROWS-1:0] ROW_RESET = 4'b1110;

  typedef enum logic [0:0] {
    KS_IDLE = 1'b0,
    KS_HELD = 1'b1
  } ks_state_t;

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/key_sync.sv
`default_nettype none
// ============================================================================
// Module    : key_sync
// Purpose   : Parameterised two-flop synchronizer. Both stages reset to
//             all-ones, the idle level of pulled-up keypad columns.
// Ports     : clk - clock
//             rst - synchronous active-low reset
//             d   - asynchronous input bus
//             q   - synchronized output bus
// Revision  : 1.0  initial release
// ============================================================================
module key_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : key_sync
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
// Module    : keypad_scan
// Purpose   : 4x4 matrix keypad scanner. Drives one row low per slot, samples
//             the synchronized columns at the end of the slot, merges a whole
//             scan into {hit, code} (lowest index wins) and debounces over
//             DEBOUNCE identical scans before reporting a press.
// Ports     : clk       - system clock
//             rst       - synchronous active-low reset
//             key_row   - row drive, active-low one-hot
//             key_col   - column returns, low = key closed in driven row
//             key_code  - code (row*4+col) of last debounced press
//             key_valid - one-cycle pulse when key_code takes a new press
//             key_down  - high while a debounced key is held
// Revision  : 1.0  initial release
// ============================================================================
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ROWS-1:0]   key_row,
  input  logic [COLS-1:0]   key_col,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_down
);

  localparam int                SLOT_W     = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [3:0]        STABLE_MAX = 4'(DEBOUNCE);

  logic [SLOT_W-1:0] slot_cnt;
  logic [1:0]        row_idx;
  logic [COLS-1:0]   col_sync;
  logic              sample_en;

  // Partial result of the scan in progress, and the last completed scan.
  logic              acc_hit;
  logic [CODE_W-1:0] acc_code;
  logic              prev_hit;
  logic [CODE_W-1:0] prev_code;
  logic [3:0]        stable_cnt;
  logic              scan_done;

  logic              row_any;
  logic [1:0]        row_col;
  logic              res_hit;
  logic [CODE_W-1:0] res_code;

  ks_state_t         state, state_nxt;
  logic              valid_nxt;
  logic [CODE_W-1:0] code_nxt;

  key_sync #(.WIDTH(COLS)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_col),
    .q   (col_sync)
  );

  assign sample_en = (slot_cnt == SLOT_LAST);

  // Lowest closed column in the currently driven row.
  always_comb begin
    row_any = ~&col_sync;
    row_col = 2'd0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!col_sync[c]) row_col = 2'(c);
    end
  end

  // A hit already found in an earlier row of this scan keeps priority.
  always_comb begin
    res_hit  = acc_hit;
    res_code = acc_code;
    if (!acc_hit && row_any) begin
      res_hit  = 1'b1;
      res_code = {row_idx, row_col};
    end
  end

  // Slot timing, row rotation, scan merge and debounce counting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_cnt   <= '0;
      row_idx    <= 2'd0;
      key_row    <= ROW_RESET;
      acc_hit    <= 1'b0;
      acc_code   <= '0;
      prev_hit   <= 1'b0;
      prev_code  <= '0;
      stable_cnt <= 4'd0;
      scan_done  <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      if (sample_en) begin
        slot_cnt <= '0;
        row_idx  <= row_idx + 2'd1;
        key_row  <= {key_row[ROWS-2:0], key_row[ROWS-1]};
        if (row_idx == 2'd3) begin
          // Scan complete: clear the accumulator for the next scan.
          acc_hit   <= 1'b0;
          acc_code  <= '0;
          scan_done <= 1'b1;
          if (res_hit == prev_hit && res_code == prev_code) begin
            if (stable_cnt != STABLE_MAX) stable_cnt <= stable_cnt + 4'd1;
          end else begin
            stable_cnt <= 4'd1;
            prev_hit   <= res_hit;
            prev_code  <= res_code;
          end
        end else begin
          acc_hit  <= res_hit;
          acc_code <= res_code;
        end
      end else begin
        slot_cnt <= slot_cnt + SLOT_W'(1);
      end
    end
  end

  // Press/release decision, one cycle after the debounce counter updates.
  always_comb begin
    state_nxt = state;
    valid_nxt = 1'b0;
    code_nxt  = key_code;
    if (scan_done && stable_cnt == STABLE_MAX) begin
      case (state)
        KS_IDLE: begin
          if (prev_hit) begin
            state_nxt = KS_HELD;
            valid_nxt = 1'b1;
            code_nxt  = prev_code;
          end
        end
        KS_HELD: begin
          // A different stable key while held is ignored until release.
          if (!prev_hit) state_nxt = KS_IDLE;
        end
        default: state_nxt = KS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= KS_IDLE;
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      state     <= state_nxt;
      key_valid <= valid_nxt;
      key_code  <= code_nxt;
    end
  end

  assign key_down = (state == KS_HELD);

endmodule : keypad_scan
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// ============================================================================
// Module    : tb_keypad_scan
// Purpose   : Self-checking bench for keypad_scan with a scan-level model of
//             the keypad behaviour and a per-cycle compare process.
// Revision  : 1.0  initial release
// ============================================================================
module tb_keypad_scan;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;

  logic       clk;
  logic       rst;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  // Physical keypad: bit i closed means key with code i (row i/4, col i%4).
  logic [15:0] pressed;

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_row   (key_row),
    .key_col   (key_col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    key_col = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      if (!key_row[r]) key_col = key_col & ~pressed[r*4 +: 4];
    end
  end

  // ---------------------------------------------------------------- model
  logic        m_live = 1'b0;
  int          n;
  logic [15:0] h1, h2;
  logic [3:0]  row_snap [4];
  logic        m_prev_hit;
  logic [3:0]  m_prev_code;
  int          m_stable;
  logic        m_held;
  logic        pend_press;
  logic [3:0]  pend_code;
  logic [3:0]  exp_row;
  logic [3:0]  exp_code;
  logic        exp_valid;
  logic        exp_down;

  always @(posedge clk) begin
    int   r;
    logic hit;
    logic [3:0] code;
    if (!rst) begin
      m_live = 1'b1; n = 0; h1 = '0; h2 = '0;
      m_prev_hit = 1'b0; m_prev_code = '0; m_stable = 0; m_held = 1'b0;
      pend_press = 1'b0; pend_code = '0;
      exp_row = 4'b1110; exp_code = '0; exp_valid = 1'b0; exp_down = 1'b0;
    end else if (m_live) begin
      exp_valid = pend_press;
      if (pend_press) exp_code = pend_code;
      exp_down   = m_held;
      pend_press = 1'b0;
      if (n % SCAN_DIV == SCAN_DIV - 1) begin
        r = (n / SCAN_DIV) % 4;
        // Columns seen at the sample went through two synchronizer stages.
        row_snap[r] = h2[r*4 +: 4];
        if (r == 3) begin
          hit = 1'b0; code = '0;
          for (int i = 0; i < 16; i++) begin
            if (!hit && row_snap[i/4][i%4]) begin hit = 1'b1; code = i[3:0]; end
          end
          if (hit == m_prev_hit && code == m_prev_code) begin
            if (m_stable < DEBOUNCE) m_stable++;
          end else begin
            m_stable = 1; m_prev_hit = hit; m_prev_code = code;
          end
          if (m_stable == DEBOUNCE) begin
            if (!m_held && hit) begin
              pend_press = 1'b1; pend_code = code; m_held = 1'b1;
            end else if (m_held && !hit) begin
              m_held = 1'b0;
            end
          end
        end
      end
      h2 = h1; h1 = pressed; n++;
      exp_row = ~(4'b0001 << ((n / SCAN_DIV) % 4));
    end
  end

  // ---------------------------------------------------------------- compare
  int          pin_req  = 0;
  int          pin_done = 0;
  string       pin_name;
  logic [4:0]  pin_mask;
  logic [3:0]  pin_row, pin_code;
  logic        pin_down, pin_flag;
  int          pin_pulses, pin_base;

  task automatic chk(input string nm, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      chk("key_row",   int'(key_row),   int'(exp_row));
      chk("key_valid", int'(key_valid), int'(exp_valid));
      chk("key_code",  int'(key_code),  int'(exp_code));
      chk("key_down",  int'(key_down),  int'(exp_down));
      if (key_valid === 1'b1) pulses++;
      if (pin_req != pin_done) begin
        if (pin_mask[0]) chk({pin_name, ":row"},    int'(key_row),  int'(pin_row));
        if (pin_mask[1]) chk({pin_name, ":code"},   int'(key_code), int'(pin_code));
        if (pin_mask[2]) chk({pin_name, ":down"},   int'(key_down), int'(pin_down));
        if (pin_mask[3]) chk({pin_name, ":pulses"}, pulses - pin_base, pin_pulses);
        if (pin_mask[4]) chk({pin_name, ":wait"},   int'(pin_flag), 1);
        pin_done = pin_req;
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic pin(input string nm, input logic [4:0] mask, input logic [3:0] row,
                     input logic [3:0] code, input logic down, input int pls,
                     input logic flag);
    pin_name = nm; pin_mask = mask; pin_row = row; pin_code = code;
    pin_down = down; pin_pulses = pls; pin_flag = flag;
    pin_req++;
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic found;
    logic [15:0] pat;
    rst = 1'b0;
    pressed = '0;
    cyc(5);
    pin("reset", 5'b00111, 4'b1110, 4'd0, 1'b0, 0, 1'b0);
    cyc(1);
    rst = 1'b1;
    cyc(4);  pin("row1", 5'b00001, 4'b1101, 4'd0, 1'b0, 0, 1'b0);
    cyc(4);  pin("row2", 5'b00001, 4'b1011, 4'd0, 1'b0, 0, 1'b0);
    cyc(4);  pin("row3", 5'b00001, 4'b0111, 4'd0, 1'b0, 0, 1'b0);
    cyc(4);  pin("row0", 5'b00001, 4'b1110, 4'd0, 1'b0, 0, 1'b0);

    // Single press of key 9 (row 2, col 1), then a long hold.
    cyc($urandom_range(1, 15));
    pin_base = pulses;
    pressed = 16'h1 << 9;
    cyc(80);  pin("press9", 5'b01110, 4'd0, 4'd9, 1'b1, 1, 1'b0);
    cyc(160); pin("hold9",  5'b01110, 4'd0, 4'd9, 1'b1, 1, 1'b0);

    // Release: key_down drops, code retained.
    pressed = '0;
    cyc(80);  pin("release9", 5'b01110, 4'd0, 4'd9, 1'b0, 1, 1'b0);

    // Bounce every 20 cycles, then hold closed.
    pin_base = pulses;
    for (int i = 0; i < 7; i++) begin
      pressed = (i % 2 == 0) ? (16'h1 << 9) : 16'h0;
      cyc(20);
    end
    pin("bounce", 5'b01000, 4'd0, 4'd0, 1'b0, 0, 1'b0);
    cyc(80);  pin("settle9", 5'b01110, 4'd0, 4'd9, 1'b1, 1, 1'b0);
    pressed = '0;
    cyc(80);

    // Multi-key and rollover.
    pin_base = pulses;
    pressed = (16'h1 << 5) | (16'h1 << 14);
    cyc(80);  pin("multi", 5'b01110, 4'd0, 4'd5, 1'b1, 1, 1'b0);
    pin_base = pulses;
    pressed = 16'h1 << 14;
    cyc(80);  pin("rollover", 5'b01110, 4'd0, 4'd5, 1'b1, 0, 1'b0);
    pressed = '0;
    cyc(80);  pin("release_all", 5'b00100, 4'd0, 4'd0, 1'b0, 0, 1'b0);
    pin_base = pulses;
    pressed = 16'h1 << 14;
    cyc(80);  pin("press14", 5'b01110, 4'd0, 4'd14, 1'b1, 1, 1'b0);
    pressed = '0;
    cyc(80);

    // Reset in the middle of debouncing key 3.
    pressed = 16'h1 << 3;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      cyc(1);
      if (m_stable == 2 && m_prev_hit && m_prev_code == 4'd3) found = 1'b1;
    end
    rst = 1'b0;
    pin("rstmid_wait", 5'b10000, 4'd0, 4'd0, 1'b0, 0, found);
    cyc(2);
    pin("rstmid_reset", 5'b00111, 4'b1110, 4'd0, 1'b0, 0, 1'b0);
    rst = 1'b1;
    pin_base = pulses;
    cyc(40);  pin("rstmid_none", 5'b01000, 4'd0, 4'd0, 1'b0, 0, 1'b0);
    cyc(40);  pin("rstmid_press3", 5'b01110, 4'd0, 4'd3, 1'b1, 1, 1'b0);

    // Randomized key activity checked by the model.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0: pat = '0;
        1: pat = 16'h1 << $urandom_range(0, 15);
        default: pat = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      endcase
      pressed = pat;
      cyc($urandom_range(1, 120));
    end
    pressed = '0;
    cyc(80);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_keypad_scan
`default_nettype wire
